// File: rtl/loader_pkg.sv
// Shared types and protocol bytes for the UART program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, ACK, ERR} state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/loader_word_packer.sv
// Assembles received bytes into a little-endian 32-bit word and keeps a running XOR
// of the bytes that belong to the program image.
module loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic        csum_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        word_full
);
  logic [1:0] idx;

  // High in the cycle the byte that completes the current word is presented.
  assign word_full = byte_vld && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (byte_vld) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;
      if (csum_en) csum <= csum ^ byte_in;
    end
  end
endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program image from the UART into memory as LE words and replies ACK/NAK.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                MAX_WORDS   = 16384,
  parameter int                TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_e           state, nxt;
  logic [CNT_W-1:0] n_words, wcnt, wcnt_inc;
  logic [31:0]      pk_word, len_full;
  logic [7:0]       pk_csum;
  logic             pk_full, pk_clr, pk_vld, accept, tmo;

  assign pk_clr    = (state == IDLE) && rx_ready && (rx_data == SYNC_BYTE);
  assign pk_vld    = rx_ready && (state == LEN || state == DATA);
  assign len_full  = {rx_data, pk_word[23:0]};
  assign wcnt_inc  = wcnt + 1'b1;
  // A byte arriving while a write is pending is an overrun: the request is withdrawn at once.
  assign mem_we    = (state == WRITE) && !rx_ready;
  assign accept    = mem_we && mem_ready;
  assign mem_wdata = pk_word;

  loader_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .byte_vld (pk_vld),
    .csum_en  (state == DATA),
    .byte_in  (rx_data),
    .word     (pk_word),
    .csum     (pk_csum),
    .word_full(pk_full)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run = state inside {LEN, DATA, CSUM};
  assign tmo     = tmo_run && !rx_ready && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Holds its value across WRITE so memory back-pressure does not count as line silence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= '0;
    else if (rx_ready || !(tmo_run || state == WRITE)) tmo_cnt <= '0;
    else if (tmo_run)                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (pk_clr) nxt = LEN;
      LEN: begin
        if (tmo) nxt = ERR;
        else if (pk_full) begin
          if (len_full == '0)                   nxt = CSUM;
          else if (len_full > 32'(MAX_WORDS))   nxt = ERR;
          else                                  nxt = DATA;
        end
      end
      DATA:  if (tmo) nxt = ERR; else if (pk_full) nxt = WRITE;
      WRITE: if (rx_ready) nxt = ERR; else if (mem_ready) nxt = (wcnt_inc == n_words) ? CSUM : DATA;
      CSUM:  if (tmo) nxt = ERR; else if (rx_ready) nxt = (rx_data == pk_csum) ? ACK : ERR;
      ACK, ERR: if (!tx_busy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      mem_addr <= BASE_ADDR;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      wcnt     <= '0;
      n_words  <= '0;
    end else begin
      tx_start <= 1'b0;
      if (pk_clr) begin
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
        mem_addr <= BASE_ADDR;
        wcnt     <= '0;
      end
      if (state == LEN && nxt == DATA) n_words <= len_full[CNT_W-1:0];
      if (accept) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        wcnt     <= wcnt_inc;
      end
      // Status, hold release and sticky flags all update on the edge that launches the reply.
      if ((state == ACK || state == ERR) && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= (state == ACK) ? ACK_BYTE : NAK_BYTE;
        cpu_hold <= 1'b0;
        done     <= (state == ACK);
        error    <= (state == ERR);
      end
    end
  end
endmodule
